// File: rtl/soc_arbiter_ahb3.sv
// soc_arbiter_ahb3: registered address/data-phase arbiter for a shared AHB3-Lite bus.
// The address-phase owner is chosen round robin. Defining SOC_ARB_FIXED_PRIORITY_EN
// switches to lowest-index-wins and removes the rotating pointer.
// Bursts (SEQ/BUSY) and locked sequences keep the bus until they finish.
// bus_hold quiesces the bus, and bus_hold_ack reports when it is idle.
module soc_arbiter_ahb3 #(
  parameter int MASTERS = 2,
  localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [MASTERS-1:0]     m_hsel_i,
  input  logic [2*MASTERS-1:0]   m_htrans_i,
  input  logic [MASTERS-1:0]     m_hmastlock_i,
  input  logic                   s_hready_i,
  input  logic                   bus_hold,
  output logic [MASTERS-1:0]     master_gnt_o,
  output logic [MW-1:0]          master_sel_o,
  output logic [MW-1:0]          data_sel_o,
  output logic                   data_valid_o,
  output logic                   bus_hold_ack
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWNED,
    ST_HOLD
  } state_t;

  state_t             state;
  logic [1:0]         htrans [MASTERS];
  logic [MASTERS-1:0] req;
  logic               owner_sticky;
  logic               win_found;
  logic [MW-1:0]      win_idx;

`ifndef SOC_ARB_FIXED_PRIORITY_EN
  logic [MW-1:0]      rr_ptr;
  int                 rr_idx;
`endif

  // Unpack per-master HTRANS and form requests (selected and NONSEQ/SEQ).
  always_comb begin
    req = '0;
    for (int i = 0; i < MASTERS; i++) begin
      htrans[i] = m_htrans_i[2*i +: 2];
      req[i]    = m_hsel_i[i] & m_htrans_i[2*i+1];
    end
  end

  // A burst in progress (SEQ/BUSY) or a locked sequence keeps the owner; dropping hsel releases it.
  assign owner_sticky = m_hsel_i[master_sel_o] &
                        (htrans[master_sel_o][0] | m_hmastlock_i[master_sel_o]);

`ifdef SOC_ARB_FIXED_PRIORITY_EN
  // Fixed priority: the lowest-index requester wins (reverse scan, the last hit is the lowest index).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = MASTERS-1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = MW'(i);
      end
    end
  end
`else
  // Round robin: search ptr+1 .. ptr+MASTERS; the reverse scan leaves the nearest requester last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = 0;
    for (int k = MASTERS; k >= 1; k--) begin
      rr_idx = int'(rr_ptr) + k;
      if (rr_idx >= MASTERS) rr_idx = rr_idx - MASTERS;
      if (req[rr_idx]) begin
        win_found = 1'b1;
        win_idx   = MW'(rr_idx);
      end
    end
  end
`endif

  // Ownership FSM, data-phase tracking and the hold handshake. Only the hold exit ignores s_hready_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      master_gnt_o <= '0;
      master_sel_o <= '0;
      data_sel_o   <= '0;
      data_valid_o <= 1'b0;
      bus_hold_ack <= 1'b0;
`ifndef SOC_ARB_FIXED_PRIORITY_EN
      rr_ptr       <= MW'(MASTERS-1);
`endif
    end else begin
      if (state == ST_HOLD) begin
        if (!bus_hold) begin
          state        <= ST_IDLE;
          bus_hold_ack <= 1'b0;
        end else begin
          bus_hold_ack <= ~data_valid_o;
        end
      end
      if (s_hready_i) begin
        if ((|master_gnt_o) && req[master_sel_o]) begin
          data_sel_o   <= master_sel_o;
          data_valid_o <= 1'b1;
        end else begin
          data_valid_o <= 1'b0;
        end
        case (state)
          ST_IDLE: begin
            if (bus_hold) begin
              state <= ST_HOLD;
            end else if (win_found) begin
              state        <= ST_OWNED;
              master_gnt_o <= MASTERS'(1) << win_idx;
              master_sel_o <= win_idx;
`ifndef SOC_ARB_FIXED_PRIORITY_EN
              rr_ptr       <= win_idx;
`endif
            end
          end
          ST_OWNED: begin
            if (owner_sticky) begin
              state <= ST_OWNED;
            end else if (bus_hold) begin
              state        <= ST_HOLD;
              master_gnt_o <= '0;
            end else if (win_found) begin
              master_gnt_o <= MASTERS'(1) << win_idx;
              master_sel_o <= win_idx;
`ifndef SOC_ARB_FIXED_PRIORITY_EN
              rr_ptr       <= win_idx;
`endif
            end else begin
              state        <= ST_IDLE;
              master_gnt_o <= '0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_soc_arbiter_ahb3.sv
// tb_soc_arbiter_ahb3: directed self-checking bench for soc_arbiter_ahb3 with MASTERS=2.
// The expected values are hand-computed. Test 1 has its own expectations for the
// SOC_ARB_FIXED_PRIORITY_EN build.
module tb_soc_arbiter_ahb3;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] m_hsel_i;
  logic [3:0] m_htrans_i;
  logic [1:0] m_hmastlock_i;
  logic       s_hready_i;
  logic       bus_hold;
  logic [1:0] master_gnt_o;
  logic [0:0] master_sel_o;
  logic [0:0] data_sel_o;
  logic       data_valid_o;
  logic       bus_hold_ack;

  int vector_count = 0;
  int miss_count   = 0;

  soc_arbiter_ahb3 #(.MASTERS(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .m_hsel_i     (m_hsel_i),
    .m_htrans_i   (m_htrans_i),
    .m_hmastlock_i(m_hmastlock_i),
    .s_hready_i   (s_hready_i),
    .bus_hold     (bus_hold),
    .master_gnt_o (master_gnt_o),
    .master_sel_o (master_sel_o),
    .data_sel_o   (data_sel_o),
    .data_valid_o (data_valid_o),
    .bus_hold_ack (bus_hold_ack)
  );

  always #5 clk_i = ~clk_i;

  task automatic applyStimulus(input logic [1:0] hsel, input logic [1:0] t0, input logic [1:0] t1,
                               input logic [1:0] lock, input logic rdy, input logic hold);
    m_hsel_i      = hsel;
    m_htrans_i    = {t1, t0};
    m_hmastlock_i = lock;
    s_hready_i    = rdy;
    bus_hold      = hold;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // The expected vector is {gnt[1:0], sel, dsel, dval, ack}.
  task automatic checkOutput(input string tag, input logic [1:0] gnt, input logic sel,
                             input logic dsel, input logic dval, input logic ack);
    logic [5:0] observed;
    logic [5:0] expected;
    observed = {master_gnt_o, master_sel_o, data_sel_o, data_valid_o, bus_hold_ack};
    expected = {gnt, sel, dsel, dval, ack};
    vector_count++;
    assert (observed === expected) else begin
      miss_count++;
      $error("[TB] FAIL %s: observed gnt/sel/dsel/dval/ack=%b expected %b", tag, observed, expected);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    applyStimulus(2'b00, IDLE, IDLE, 2'b00, 1'b1, 1'b0);
    #2;
    checkOutput("reset", 2'b00, 0, 0, 0, 0);
    #10;
    rst_i = 1'b0;

    // Test 1: two NONSEQ singles alternate.
    applyStimulus(2'b11, NONSEQ, NONSEQ, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("t1_e1", 2'b01, 0, 0, 0, 0);
    tick();
`ifdef SOC_ARB_FIXED_PRIORITY_EN
    checkOutput("t1_e2", 2'b01, 0, 0, 1, 0);
    tick();
    checkOutput("t1_e3", 2'b01, 0, 0, 1, 0);
    applyStimulus(2'b00, IDLE, IDLE, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("t1_idle", 2'b00, 0, 0, 0, 0);
`else
    checkOutput("t1_e2", 2'b10, 1, 0, 1, 0);
    tick();
    checkOutput("t1_e3", 2'b01, 0, 1, 1, 0);
    applyStimulus(2'b00, IDLE, IDLE, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("t1_idle", 2'b00, 0, 1, 0, 0);
`endif

    // Test 2: m0 INCR4 burst holds the bus against m1.
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    applyStimulus(2'b11, NONSEQ, NONSEQ, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("t2_grant", 2'b01, 0, 0, 0, 0);
    applyStimulus(2'b11, SEQ, NONSEQ, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("t2_seq1", 2'b01, 0, 0, 1, 0);
    tick();
    checkOutput("t2_seq2", 2'b01, 0, 0, 1, 0);
    tick();
    checkOutput("t2_seq3", 2'b01, 0, 0, 1, 0);
    applyStimulus(2'b11, IDLE, NONSEQ, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("t2_switch", 2'b10, 1, 0, 0, 0);

    // Test 3: a stalled data phase freezes the grant.
    applyStimulus(2'b11, NONSEQ, IDLE, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("t3_grant", 2'b01, 0, 0, 0, 0);
    applyStimulus(2'b11, SEQ, NONSEQ, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("t3_seq", 2'b01, 0, 0, 1, 0);
    applyStimulus(2'b11, IDLE, NONSEQ, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("t3_stall%0d", i), 2'b01, 0, 0, 1, 0);
    end
    applyStimulus(2'b11, IDLE, NONSEQ, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("t3_release", 2'b10, 1, 0, 0, 0);

    // Test 4: a locked sequence of m0 singles keeps m1 out.
    applyStimulus(2'b11, NONSEQ, IDLE, 2'b01, 1'b1, 1'b0);
    tick();
    checkOutput("t4_grant", 2'b01, 0, 0, 0, 0);
    applyStimulus(2'b11, NONSEQ, NONSEQ, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("t4_lock%0d", i), 2'b01, 0, 0, 1, 0);
    end
    applyStimulus(2'b11, IDLE, NONSEQ, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("t4_unlock", 2'b10, 1, 0, 0, 0);

    // Test 5: the bus_hold quiesce handshake, with the exit taken during a stall.
    applyStimulus(2'b11, NONSEQ, NONSEQ, 2'b00, 1'b1, 1'b1);
    tick();
    checkOutput("t5_hold", 2'b00, 1, 1, 1, 0);
    applyStimulus(2'b01, NONSEQ, IDLE, 2'b00, 1'b1, 1'b1);
    tick();
    checkOutput("t5_drain", 2'b00, 1, 1, 0, 0);
    tick();
    checkOutput("t5_ack", 2'b00, 1, 1, 0, 1);
    applyStimulus(2'b01, NONSEQ, IDLE, 2'b00, 1'b0, 1'b0);
    tick();
    checkOutput("t5_unhold", 2'b00, 1, 1, 0, 0);
    applyStimulus(2'b01, NONSEQ, IDLE, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("t5_regrant", 2'b01, 0, 1, 0, 0);

    // Test 6: an asynchronous reset in the middle of an m1 burst.
    applyStimulus(2'b11, IDLE, NONSEQ, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("t6_grant", 2'b10, 1, 1, 0, 0);
    applyStimulus(2'b11, IDLE, SEQ, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("t6_burst", 2'b10, 1, 1, 1, 0);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("t6_async", 2'b00, 0, 0, 0, 0);
    applyStimulus(2'b11, NONSEQ, NONSEQ, 2'b00, 1'b1, 1'b0);
    #2;
    rst_i = 1'b0;
    tick();
    checkOutput("t6_first", 2'b01, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule

// File: doc/soc_arbiter_ahb3.md
Name: soc_arbiter_ahb3

Overview:
- Registered master-side arbiter for the shared AHB3-Lite bus between N masters and the slave decoder.
- Decides which master owns the address phase and tracks which master owns the outstanding data phase.
- Implements the bus_hold / bus_hold_ack quiesce handshake.
- The mux steers address, write data, read data and hready from master_sel_o and data_sel_o.

Parameters:
MASTERS, 2, number of requesting masters (1..16)
MW, derived = (MASTERS>1) ? $clog2(MASTERS) : 1, index width (localparam)

Ports:
clk_i  input  1  bus clock
rst_i  input  1  asynchronous active-high reset
m_hsel_i  input  MASTERS  per-master select
m_htrans_i  input  MASTERS x 2  per-master HTRANS (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
m_hmastlock_i  input  MASTERS  per-master locked-sequence flag
s_hready_i  input  1  bus HREADY from decoder (end of current data phase)
bus_hold  input  1  request to quiesce the bus
master_gnt_o  output  MASTERS  one-hot address-phase grant, all-zero when no owner
master_sel_o  output  MW  index of address-phase owner
data_sel_o  output  MW  index of data-phase owner
data_valid_o  output  1  data phase outstanding
bus_hold_ack  output  1  bus quiesced, no grant, no outstanding data phase

Behaviour:
- One clock, clk_i; reset rst_i is asynchronous and active-high. All outputs and state are registered.
- Reset values:
  - master_gnt_o=0, master_sel_o=0, data_sel_o=0, data_valid_o=0, bus_hold_ack=0.
  - State=IDLE; round-robin pointer=MASTERS-1, so master 0 has first priority.
- Request definition: req[i] = m_hsel_i[i] & m_htrans_i[i][1].
- Decision point: arbitration, grant change and data-phase tracking update only on clock edges where s_hready_i=1. With s_hready_i=0, all state holds.
- States:
  - IDLE: no owner, gnt=0.
    - bus_hold=1 -> HOLD.
    - else any req -> OWNED, granting the winner.
  - OWNED: owner o.
    - Keep (sticky) while m_htrans_i[o] is SEQ or BUSY, or m_hmastlock_i[o]=1.
    - Otherwise, if bus_hold=1 -> HOLD with gnt=0.
    - Otherwise re-arbitrate among all req including o. If no req -> IDLE.
  - HOLD: gnt=0.
    - bus_hold_ack=1 from the edge after HOLD is entered with data_valid_o=0.
    - bus_hold=0 -> ack drops next edge, state -> IDLE. Leaving HOLD is evaluated every edge, independent of s_hready_i.
- Round robin:
  - Winner = first i with req[i], searching ptr+1 .. ptr+MASTERS, mod MASTERS.
  - ptr <= winner on every new grant.
  - The owner finishing a NONSEQ single while others request yields to the next requester.
- Data-phase tracking, on edges with s_hready_i=1:
  - If gnt is non-zero and req[master_sel_o]: data_sel_o <= master_sel_o, data_valid_o <= 1.
  - Else data_valid_o <= 0; data_sel_o holds.
- Simultaneous events:
  - bus_hold beats new requests, except when the owner is sticky; a burst or locked sequence completes first.
  - An owner dropping m_hsel_i mid-burst (protocol violation) is treated as req=0, releasing the bus.
- Reset mid-burst: outputs return to reset values immediately; no partial-transfer recovery.
- MASTERS=1: grant is still registered; ownership follows the same rules.

Optional Feature:
- Macro: SOC_ARB_FIXED_PRIORITY_EN.
- Defined: winner = lowest-index requester; the pointer is not implemented; stickiness and hold rules are unchanged.
- Undefined: round robin as above.

Test Plan:
1. Reset; m0 and m1 both NONSEQ singles, s_hready_i=1 -> gnt=01 at edge 1; gnt=10 at edge 2; data_sel_o=0, data_valid_o=1 at edge 2; data_sel_o=1 at edge 3.
2. m0 INCR4 (NONSEQ, SEQ, SEQ, SEQ) while m1 requests -> gnt=01 for all 4 address phases; gnt=10 on the edge after the last SEQ.
3. m0 single done, m1 requesting, s_hready_i=0 for 3 cycles -> gnt stays 01, data_valid_o stays 1; switch to 10 on the first edge with s_hready_i=1.
4. m0 m_hmastlock_i=1 across 3 NONSEQ singles with m1 requesting -> m1 never granted until lock drops; then gnt=10.
5. bus_hold=1 during m1 single -> gnt=00 after hready edge; data_valid_o=0 next hready edge; bus_hold_ack=1 the edge after. bus_hold=0 -> ack=0 next edge; pending m0 req gets gnt=01.
6. Assert rst_i mid-burst (m1 SEQ) -> all outputs zero without a clock edge; after release, first grant goes to master 0. With SOC_ARB_FIXED_PRIORITY_EN, repeat test 1 -> m0 wins both rounds while it keeps requesting.
